// File: rtl/pr_free_list.sv
// -----------------------------------------------------------------------------
// pr_free_list
//   Circular free list of physical register (PR) numbers for the rename stage.
//   The head supplies p_rd_new to the map table at dispatch. Free PRs come back
//   at the tail from two sources:
//     - retirement, which returns the previous mapping of the committing
//       instruction;
//     - recovery walk-back, which returns the p_rd of squashed instructions.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   alloc_req           dispatch wants a new PR this cycle
//   recover             recovery in progress; no grants are given
//   p_rd_new            PR at head of list (valid when !fl_empty)
//   alloc_gnt           allocation taken this cycle
//   fl_empty            no free PR held
//   fl_count            number of free PRs held, 0..DEPTH
//   retire_free/_pr     free a PR from the committing instruction
//   flush_free/_pr      free a PR from the ROB walk-back entry
//   fl_overflow         sticky flag: a free was dropped because the list was full
// -----------------------------------------------------------------------------
module pr_free_list #(
  parameter int NUM_PR = 64,
  parameter int NUM_LR = 32,
  parameter int PR_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_req,
  input  logic            recover,
  output logic [PR_W-1:0] p_rd_new,
  output logic            alloc_gnt,
  output logic            fl_empty,
  output logic [PR_W-1:0] fl_count,
  input  logic            retire_free,
  input  logic [PR_W-1:0] retire_pr,
  input  logic            flush_free,
  input  logic [PR_W-1:0] flush_pr,
  output logic            fl_overflow
);

  localparam int DEPTH = NUM_PR - NUM_LR;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ZERO_C = {(PTR_W+1){1'b0}};

  logic [PR_W-1:0]  entry_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   cnt_r;
  logic             ovf_r;

  logic             gnt_s;
  logic             ret_ok_s;
  logic             fl_ok_s;
  logic             drop_s;
  logic [PTR_W:0]   cnt_pop_s;
  logic [PTR_W:0]   cnt_ret_s;
  logic [PTR_W:0]   cnt_next_s;
  logic [PTR_W-1:0] fl_slot_s;
  logic [PTR_W-1:0] tail_next_s;

  // Grant and push acceptance. Capacity is checked in the order pop, retire
  // push, flush push, so a pop in the same cycle makes room for one push.
  // There is no bypass: a grant depends only on the registered count.
  always_comb begin
    gnt_s       = alloc_req && !recover && (cnt_r != ZERO_C);
    cnt_pop_s   = cnt_r - {{PTR_W{1'b0}}, gnt_s};
    ret_ok_s    = retire_free && (cnt_pop_s < FULL_C);
    cnt_ret_s   = cnt_pop_s + {{PTR_W{1'b0}}, ret_ok_s};
    fl_ok_s     = flush_free && (cnt_ret_s < FULL_C);
    cnt_next_s  = cnt_ret_s + {{PTR_W{1'b0}}, fl_ok_s};
    // Flush push lands one slot past the retire push when both are taken.
    fl_slot_s   = tail_r + {{(PTR_W-1){1'b0}}, ret_ok_s};
    tail_next_s = fl_slot_s + {{(PTR_W-1){1'b0}}, fl_ok_s};
    drop_s      = (retire_free && !ret_ok_s) || (flush_free && !fl_ok_s);
  end

  // Storage: reset loads PRs NUM_LR..NUM_PR-1; accepted pushes write at tail.
  // When full, a pop frees the head slot which equals tail, so the write there
  // at the edge does not disturb the value read out this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= PR_W'(NUM_LR + i);
      end
    end else begin
      if (ret_ok_s) begin
        entry_r[tail_r] <= retire_pr;
      end
      if (fl_ok_s) begin
        entry_r[fl_slot_s] <= flush_pr;
      end
    end
  end

  // Pointers, count and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      cnt_r  <= FULL_C;
      ovf_r  <= 1'b0;
    end else begin
      head_r <= head_r + {{(PTR_W-1){1'b0}}, gnt_s};
      tail_r <= tail_next_s;
      cnt_r  <= cnt_next_s;
      ovf_r  <= ovf_r | drop_s;
    end
  end

  assign p_rd_new    = entry_r[head_r];
  assign alloc_gnt   = gnt_s;
  assign fl_empty    = (cnt_r == ZERO_C);
  assign fl_count    = PR_W'(cnt_r);
  assign fl_overflow = ovf_r;

endmodule

// File: tb/tb_pr_free_list.sv
// -----------------------------------------------------------------------------
// tb_pr_free_list
//   Directed bench for pr_free_list. Inputs change on the falling edge and
//   outputs are compared 1 time unit later, half a period away from the
//   active rising edge.
// -----------------------------------------------------------------------------
module tb_pr_free_list;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       recover;
  logic [5:0] p_rd_new;
  logic       alloc_gnt;
  logic       fl_empty;
  logic [5:0] fl_count;
  logic       retire_free;
  logic [5:0] retire_pr;
  logic       flush_free;
  logic [5:0] flush_pr;
  logic       fl_overflow;

  int checks;
  int failures;

  pr_free_list #(.NUM_PR(64), .NUM_LR(32), .PR_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (alloc_req),
    .recover     (recover),
    .p_rd_new    (p_rd_new),
    .alloc_gnt   (alloc_gnt),
    .fl_empty    (fl_empty),
    .fl_count    (fl_count),
    .retire_free (retire_free),
    .retire_pr   (retire_pr),
    .flush_free  (flush_free),
    .flush_pr    (flush_pr),
    .fl_overflow (fl_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle.
  task automatic drive(input logic a, input logic rec, input logic rf, input logic [5:0] rp,
                       input logic ff, input logic [5:0] fp);
    @(negedge clk);
    alloc_req   = a;
    recover     = rec;
    retire_free = rf;
    retire_pr   = rp;
    flush_free  = ff;
    flush_pr    = fp;
    #1;
  endtask

  initial begin
    logic [5:0] exp_q[$];
    logic [5:0] exp_v;
    logic [5:0] v;
    logic [5:0] drain [11];

    checks = 0;
    failures = 0;
    alloc_req = 1'b0; recover = 1'b0;
    retire_free = 1'b0; retire_pr = 6'd0;
    flush_free = 1'b0; flush_pr = 6'd0;

    // ---- 1: reset values, then drain all 32 free PRs in order
    rst = 1'b1;
    #2;
    chk("rst_p_rd_new", p_rd_new, 32);
    chk("rst_fl_count", fl_count, 32);
    chk("rst_fl_empty", fl_empty, 0);
    chk("rst_alloc_gnt", alloc_gnt, 0);
    chk("rst_overflow", fl_overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("t1_p_rd_new", p_rd_new, 32 + i);
      chk("t1_gnt", alloc_gnt, 1);
      chk("t1_count", fl_count, 32 - i);
    end
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("t1_empty", fl_empty, 1);
    chk("t1_count0", fl_count, 0);
    chk("t1_no_gnt", alloc_gnt, 0);

    // ---- 2: push into empty list is not allocatable in the same cycle
    drive(1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 6'd0);
    chk("t2_no_bypass_gnt", alloc_gnt, 0);
    chk("t2_still_empty", fl_empty, 1);
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("t2_p_rd_new", p_rd_new, 5);
    chk("t2_gnt", alloc_gnt, 1);
    chk("t2_count", fl_count, 1);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("t2_empty_again", fl_empty, 1);

    // ---- 3: fill to 10, then pop + retire + flush in one cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 6'(20 + i), 1'b0, 6'd0);
    end
    drive(1'b1, 1'b0, 1'b1, 6'd7, 1'b1, 6'd40);
    chk("t3_count10", fl_count, 10);
    chk("t3_gnt", alloc_gnt, 1);
    chk("t3_head", p_rd_new, 20);
    for (int i = 0; i < 9; i++) drain[i] = 6'(21 + i);
    drain[9] = 6'd7;
    drain[10] = 6'd40;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      if (i == 0) chk("t3_count11", fl_count, 11);
      chk("t3_drain", p_rd_new, drain[i]);
      chk("t3_drain_gnt", alloc_gnt, 1);
    end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("t3_count_end", fl_count, 0);

    // ---- 4: recovery blocks grants, flushed PRs appended in walk-back order
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 6'd50);
    chk("t4_gnt_a", alloc_gnt, 0);
    chk("t4_count_a", fl_count, 0);
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 6'd49);
    chk("t4_gnt_b", alloc_gnt, 0);
    chk("t4_count_b", fl_count, 1);
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 6'd48);
    chk("t4_gnt_c", alloc_gnt, 0);
    chk("t4_count_c", fl_count, 2);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("t4_count3", fl_count, 3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("t4_order", p_rd_new, 50 - i);
      chk("t4_gnt", alloc_gnt, 1);
    end

    // ---- 5: overflow at full, then asynchronous reset mid-cycle
    @(negedge clk);
    alloc_req = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 6'd9, 1'b1, 6'd11);
    chk("t5_full_count", fl_count, 32);
    chk("t5_full_gnt", alloc_gnt, 1);
    chk("t5_ovf_pre", fl_overflow, 0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("t5_count_kept", fl_count, 32);
    chk("t5_ovf_flush_drop", fl_overflow, 1);
    chk("t5_head_moved", p_rd_new, 33);
    drive(1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 6'd0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("t5_retire_drop_count", fl_count, 32);
    chk("t5_ovf_sticky", fl_overflow, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_ovf", fl_overflow, 0);
    chk("t5_rst_p_rd_new", p_rd_new, 32);
    chk("t5_rst_count", fl_count, 32);
    @(negedge clk);
    rst = 1'b0;

    // ---- 6: 40 cycles of alloc + retire, pointers wrap, FIFO order kept
    for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
    for (int i = 0; i < 40; i++) begin
      v = 6'((i * 7 + 3) % 64);
      drive(1'b1, 1'b0, 1'b1, v, 1'b0, 6'd0);
      exp_v = exp_q.pop_front();
      chk("t6_pop", p_rd_new, exp_v);
      chk("t6_gnt", alloc_gnt, 1);
      chk("t6_count", fl_count, 32);
      exp_q.push_back(v);
    end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    chk("t6_count_end", fl_count, 32);
    chk("t6_no_ovf", fl_overflow, 0);
    chk("t6_head_after_wrap", p_rd_new, exp_q[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
